// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-16 checker: width, feedback taps and FSM states.
// Polynomial x^16+x^14+x^13+x^11+1 with c[0] = newest bit.
package prbs_pkg;

   localparam int unsigned PRBS_W = 16;

   localparam int unsigned TAP_A = 15;
   localparam int unsigned TAP_B = 13;
   localparam int unsigned TAP_C = 12;
   localparam int unsigned TAP_D = 10;

   localparam logic [PRBS_W-1:0] PRBS_TAP_MASK =
      (PRBS_W'(1) << TAP_A) | (PRBS_W'(1) << TAP_B) |
      (PRBS_W'(1) << TAP_C) | (PRBS_W'(1) << TAP_D);

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   // Next expected stream bit, predicted from the last 16 received bits.
   function automatic logic prbs_predict(input logic [PRBS_W-1:0] c);
      return ^(c & PRBS_TAP_MASK);
   endfunction

endpackage

// File: rtl/prbs_checker.sv
// PRBS-16 receive checker: seeds from the stream, verifies, then free-runs a local
// generator while counting bit errors and dropping lock when a window gets too noisy.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int unsigned LOCK_CNT   = 32,
   parameter int unsigned WINDOW     = 64,
   parameter int unsigned ERR_THRESH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   input  logic        din_valid,
   input  logic        err_clr,
   output logic        locked,
   output logic        err,
   output logic [15:0] err_count
);

   localparam int unsigned SW = $clog2(PRBS_W);
   localparam int unsigned MW = $clog2(LOCK_CNT + 1);
   localparam int unsigned WW = $clog2(WINDOW);
   localparam int unsigned EW = $clog2(ERR_THRESH + 1);

   localparam logic [SW-1:0] SEED_LAST  = SW'(PRBS_W - 1);
   localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
   localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
   localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_THRESH - 1);

   state_e            state_q;
   logic [PRBS_W-1:0] c_q;
   logic [SW-1:0]     seed_cnt_q;
   logic [MW-1:0]     match_cnt_q;
   logic [WW-1:0]     win_cnt_q;
   logic [EW-1:0]     win_err_q;
   logic              locked_q;
   logic              err_q;
   logic [15:0]       err_count_q;

   logic              p;
   logic              miss;
   logic              hit;
   logic [PRBS_W-1:0] c_din_d;
   logic [15:0]       err_count_d;

   always_comb begin
      p       = prbs_predict(c_q);
      miss    = din ^ p;
      hit     = din_valid && (state_q == ST_LOCKED) && miss;
      c_din_d = {c_q[PRBS_W-2:0], din};
   end

   // A clear in the same cycle as a counted error leaves that error counted.
   always_comb begin
      err_count_d = err_count_q;
      if (err_clr)
         err_count_d = hit ? 16'd1 : 16'd0;
      else if (hit && (err_count_q != '1))
         err_count_d = err_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SEED;
         c_q         <= '0;
         seed_cnt_q  <= '0;
         match_cnt_q <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         err_q       <= 1'b0;
         err_count_q <= err_count_d;
         if (din_valid) begin
            unique case (state_q)
               ST_SEED: begin
                  c_q <= c_din_d;
                  if (seed_cnt_q == SEED_LAST) begin
                     seed_cnt_q <= '0;
                     if (c_din_d != '0)
                        state_q <= ST_VERIFY;
                  end else begin
                     seed_cnt_q <= seed_cnt_q + SW'(1);
                  end
               end
               ST_VERIFY: begin
                  c_q <= c_din_d;
                  if (miss) begin
                     state_q     <= ST_SEED;
                     seed_cnt_q  <= '0;
                     match_cnt_q <= '0;
                  end else if (match_cnt_q == MATCH_LAST) begin
                     state_q     <= ST_LOCKED;
                     locked_q    <= 1'b1;
                     match_cnt_q <= '0;
                     win_cnt_q   <= '0;
                     win_err_q   <= '0;
                  end else begin
                     match_cnt_q <= match_cnt_q + MW'(1);
                  end
               end
               ST_LOCKED: begin
                  // Shift the prediction, not din, so the generator free-runs.
                  c_q   <= {c_q[PRBS_W-2:0], p};
                  err_q <= miss;
                  if (miss && (win_err_q == ERR_LAST)) begin
                     state_q     <= ST_SEED;
                     locked_q    <= 1'b0;
                     seed_cnt_q  <= '0;
                     match_cnt_q <= '0;
                     win_cnt_q   <= '0;
                     win_err_q   <= '0;
                  end else if (win_cnt_q == WIN_LAST) begin
                     win_cnt_q <= '0;
                     win_err_q <= '0;
                  end else begin
                     win_cnt_q <= win_cnt_q + WW'(1);
                     win_err_q <= win_err_q + {{(EW-1){1'b0}}, miss};
                  end
               end
               default: begin
                  state_q  <= ST_SEED;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign locked    = locked_q;
   assign err       = err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a reference PRBS-16 source with per-index bit
// flips, and per-scenario tasks checking lock/err timing against hand-derived indices.
module tb_prbs_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        din = 1'b0;
   logic        din_valid = 1'b0;
   logic        err_clr = 1'b0;
   logic        locked;
   logic        err;
   logic [15:0] err_count;

   always #5 clk = ~clk;

   prbs_checker #(
      .LOCK_CNT   (32),
      .WINDOW     (64),
      .ERR_THRESH (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .err_clr   (err_clr),
      .locked    (locked),
      .err       (err),
      .err_count (err_count)
   );

   int checks = 0;
   int fails  = 0;

   logic [15:0] gen;
   int          n;
   bit          flips [int];
   int          cur_idx;
   int          err_pulses;
   int          err_idx;
   int          last_rise;
   int          last_fall;
   int          bad_idle;
   logic        prev_locked;

   // One clock: drive on the falling edge, observe 1 time unit after the rising edge.
   task automatic step(input logic b, input logic v, input logic clr, input logic r);
      @(negedge clk);
      din       = b;
      din_valid = v;
      err_clr   = clr;
      rst       = r;
      @(posedge clk);
      #1;
      if (!r) begin
         if (!v && (err === 1'b1 || locked !== prev_locked)) bad_idle++;
         if (err === 1'b1) begin
            err_pulses++;
            err_idx = cur_idx;
         end
         if (locked === 1'b1 && prev_locked !== 1'b1) last_rise = cur_idx;
         if (locked === 1'b0 && prev_locked === 1'b1) last_fall = cur_idx;
      end
      prev_locked = locked;
   endtask

   task automatic send(input logic clr);
      logic b;
      b   = gen[15] ^ gen[13] ^ gen[12] ^ gen[10];
      gen = {gen[14:0], b};
      cur_idx = n;
      if (flips.exists(n)) b = ~b;
      n++;
      step(b, 1'b1, clr, 1'b0);
   endtask

   task automatic send_n(input int count);
      for (int i = 0; i < count; i++) send(1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b1);
      rst        = 1'b0;
      gen        = 16'h0001;
      n          = 0;
      cur_idx    = -1;
      flips.delete();
      err_pulses = 0;
      err_idx    = -1;
      last_rise  = -1;
      last_fall  = -1;
      bad_idle   = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
      checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (err_count !== 16'd0) begin fails++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
   endtask

   task automatic test_lock();
      do_reset();
      send_n(10000);
      checks++; if (last_rise !== 47) begin fails++; $display("FAIL lock_latency: rose after bit %0d want 47", last_rise); end
      checks++; if (err_pulses !== 0) begin fails++; $display("FAIL lock_clean_err: %0d pulses want 0", err_pulses); end
      checks++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_hold: got %b want 1", locked); end
      checks++; if (last_fall !== -1) begin fails++; $display("FAIL lock_no_fall: fell after bit %0d want none", last_fall); end
   endtask

   task automatic test_single_error();
      do_reset();
      flips[200] = 1'b1;
      send_n(300);
      checks++; if (err_pulses !== 1) begin fails++; $display("FAIL single_pulses: got %0d want 1", err_pulses); end
      checks++; if (err_idx !== 200) begin fails++; $display("FAIL single_err_time: after bit %0d want 200", err_idx); end
      checks++; if (err_count !== 16'd1) begin fails++; $display("FAIL single_err_count: got %0d want 1", err_count); end
      checks++; if (locked !== 1'b1 || last_fall !== -1) begin fails++; $display("FAIL single_locked: locked %b fall %0d want 1/-1", locked, last_fall); end
   endtask

   task automatic test_loss_of_lock();
      do_reset();
      for (int i = 60; i <= 74; i += 2) flips[i] = 1'b1;
      send_n(200);
      checks++; if (last_fall !== 74) begin fails++; $display("FAIL lol_fall: after bit %0d want 74", last_fall); end
      checks++; if (err_count !== 16'd8) begin fails++; $display("FAIL lol_err_count: got %0d want 8", err_count); end
      checks++; if (err_pulses !== 8) begin fails++; $display("FAIL lol_pulses: got %0d want 8", err_pulses); end
      checks++; if (last_rise !== 122) begin fails++; $display("FAIL lol_relock: after bit %0d want 122", last_rise); end
      checks++; if (locked !== 1'b1) begin fails++; $display("FAIL lol_final_locked: got %b want 1", locked); end
   endtask

   task automatic test_window_boundary();
      // 8th error lands on the last bit of the first locked window (bit 111).
      do_reset();
      for (int i = 104; i <= 111; i++) flips[i] = 1'b1;
      send_n(130);
      checks++; if (last_fall !== 111) begin fails++; $display("FAIL win_last_bit: fell after bit %0d want 111", last_fall); end
      // 7 errors, then the 8th just past the window end: stays locked.
      do_reset();
      for (int i = 104; i <= 110; i++) flips[i] = 1'b1;
      flips[112] = 1'b1;
      send_n(200);
      checks++; if (last_fall !== -1 || locked !== 1'b1) begin fails++; $display("FAIL win_split: fell %0d locked %b want -1/1", last_fall, locked); end
      checks++; if (err_count !== 16'd8) begin fails++; $display("FAIL win_split_count: got %0d want 8", err_count); end
   endtask

   task automatic test_stuck();
      do_reset();
      for (int i = 0; i < 1000; i++) begin cur_idx = i; step(1'b0, 1'b1, 1'b0, 1'b0); end
      checks++; if (last_rise !== -1 || locked !== 1'b0) begin fails++; $display("FAIL stuck0: rose %0d locked %b want -1/0", last_rise, locked); end
      do_reset();
      for (int i = 0; i < 1000; i++) begin cur_idx = i; step(1'b1, 1'b1, 1'b0, 1'b0); end
      checks++; if (last_rise !== -1 || locked !== 1'b0) begin fails++; $display("FAIL stuck1: rose %0d locked %b want -1/0", last_rise, locked); end
      checks++; if (err_pulses !== 0) begin fails++; $display("FAIL stuck_err: got %0d pulses want 0", err_pulses); end
   endtask

   task automatic test_gapped_valid();
      do_reset();
      flips[200] = 1'b1;
      for (int i = 0; i < 300; i++) begin
         while ($urandom_range(0, 1) == 0)
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
         send(1'b0);
      end
      checks++; if (last_rise !== 47) begin fails++; $display("FAIL gap_lock: rose after bit %0d want 47", last_rise); end
      checks++; if (err_pulses !== 1 || err_idx !== 200) begin fails++; $display("FAIL gap_err: %0d pulses at %0d want 1 at 200", err_pulses, err_idx); end
      checks++; if (err_count !== 16'd1) begin fails++; $display("FAIL gap_err_count: got %0d want 1", err_count); end
      checks++; if (bad_idle !== 0) begin fails++; $display("FAIL gap_idle_change: %0d idle cycles changed outputs want 0", bad_idle); end
   endtask

   task automatic test_err_clr_and_reset();
      do_reset();
      flips[200] = 1'b1;
      flips[210] = 1'b1;
      flips[220] = 1'b1;
      flips[230] = 1'b1;
      send_n(220);
      checks++; if (err_count !== 16'd2) begin fails++; $display("FAIL clr_pre: got %0d want 2", err_count); end
      send(1'b1);
      checks++; if (err_count !== 16'd1 || err !== 1'b1) begin fails++; $display("FAIL clr_with_err: count %0d err %b want 1/1", err_count, err); end
      send(1'b1);
      checks++; if (err_count !== 16'd0) begin fails++; $display("FAIL clr_alone: got %0d want 0", err_count); end
      send_n(9);
      checks++; if (err_count !== 16'd1 || err !== 1'b1) begin fails++; $display("FAIL clr_after: count %0d err %b want 1/1", err_count, err); end
      step(1'b1, 1'b1, 1'b0, 1'b1);
      rst = 1'b0;
      checks++; if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0) begin fails++; $display("FAIL rst_mid_locked: locked %b err %b count %0d want 0/0/0", locked, err, err_count); end
      gen       = 16'h0001;
      n         = 0;
      last_rise = -1;
      flips.delete();
      send_n(60);
      checks++; if (last_rise !== 47) begin fails++; $display("FAIL rst_relock: rose after bit %0d want 47", last_rise); end
   endtask

   initial begin
      prev_locked = 1'b0;
      test_reset();
      test_lock();
      test_single_error();
      test_loss_of_lock();
      test_window_boundary();
      test_stuck();
      test_gapped_valid();
      test_err_clr_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_CNT, default 32: consecutive matching bits required in VERIFY before lock.
REQ-002 Parameter WINDOW, default 64: length of the loss-of-lock window, in valid bits.
REQ-003 Parameter ERR_THRESH, default 8: mismatches within one window that force loss of lock.
REQ-004 clk  input  1  clock; all logic SHALL be rising-edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 din  input  1  received PRBS bit, sampled only when din_valid=1.
REQ-007 din_valid  input  1  qualifies din; a cycle with din_valid=0 SHALL change no state.
REQ-008 err_clr  input  1  synchronous clear of err_count.
REQ-009 locked  output  1  registered; 1 while the FSM is in LOCKED.
REQ-010 err  output  1  registered one-cycle pulse per mismatched bit in LOCKED.
REQ-011 err_count  output  16  registered, saturating total of LOCKED mismatches.

Function
REQ-012 Polynomial x^16+x^14+x^13+x^11+1; stream recurrence b(n)=b(n-16)^b(n-14)^b(n-13)^b(n-11).
REQ-013 The 16-bit history register c SHALL hold c[0]=newest bit and c[15]=oldest; prediction p=c[15]^c[13]^c[12]^c[10].
REQ-014 FSM states SHALL be SEED, VERIFY and LOCKED.
REQ-015 SEED: each valid bit SHALL shift into c, with c <= {c[14:0],din}, and increment a seed counter.
REQ-016 SEED exit after 16 valid bits: if c is nonzero, go to VERIFY; if c is all-zero, stay in SEED and restart the count.
REQ-017 VERIFY: each valid bit SHALL be compared with p, and din (not p) SHALL shift into c.
REQ-018 VERIFY match SHALL increment the match counter; reaching LOCK_CNT SHALL go to LOCKED.
REQ-019 VERIFY mismatch SHALL go to SEED, with the seed and match counters cleared; err is not pulsed and err_count is not changed.
REQ-020 LOCKED: p (not din) SHALL shift into c, so that the local generator free-runs and one flipped bit yields exactly one error.
REQ-021 LOCKED mismatch: err=1 on the next cycle, and err_count increments unless it equals 16'hFFFF.
REQ-022 LOCKED window: a window counter SHALL count valid bits 0..WINDOW-1; a window-error counter SHALL count mismatches.
REQ-023 When window errors reach ERR_THRESH, the FSM SHALL go to SEED, with locked=0 on the next cycle and the window counters cleared.
REQ-024 At the window end (bit WINDOW-1), both window counters SHALL clear; a mismatch on that bit counts toward the threshold first.
REQ-025 Latency: locked and err SHALL change one cycle after the valid bit that causes them.
REQ-026 err_clr together with a counted mismatch in the same cycle SHALL give err_count=1; err_clr alone SHALL give 0.
REQ-027 Loss of lock SHALL NOT clear err_count.

Reset
REQ-028 On rst=1 at a clock edge: state=SEED, c=0, all internal counters=0, locked=0, err=0, err_count=0.
REQ-029 rst SHALL dominate din_valid and err_clr, including mid-VERIFY and mid-LOCKED.

Structure
REQ-030 Shared package prbs_pkg SHALL hold: PRBS_W=16, the tap positions {15,13,12,10}, and the FSM state enum.
REQ-031 No sub-module: the feedback XOR, FSM and counters are a single module of about 150-250 lines.

Verification
REQ-032 Feed the 16-bit generator stream (seed 1) continuously from reset -> locked rises on the cycle after the 48th valid bit, and err stays 0 for 10000 bits.
REQ-033 Once locked, invert stream bit 200 -> exactly one err pulse, err_count=1, and locked stays 1.
REQ-034 Once locked, invert 8 bits within one 64-bit window -> err_count=8, locked=0 on the cycle after the 8th error, then relock after a further 48 clean bits.
REQ-035 din held at 0 (or 1) for 1000 bits -> locked never asserts.
REQ-036 Toggle din_valid randomly (50% duty) with a valid stream -> locking and error results are identical to the continuous case.
REQ-037 err_clr in the same cycle as a counted mismatch -> err_count=1; assert rst mid-LOCKED -> all outputs 0 on the next cycle.
